// File: rtl/register_file.sv
// Architectural register file with rename-tag table for the Tomasulo core.
// Optional build macro RF_CMT_BYPASS_EN forwards a same-cycle commit into the issue lookup.
module register_file #(
  parameter int DAT_W   = 32,
  parameter int REG_BIT = 5,
  parameter int ROB_BIT = 5,
  parameter int OP_W    = 6,
  parameter int ADR_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               is_en_i,
  input  logic               is_ls_i,
  input  logic [REG_BIT-1:0] is_rs1_i,
  input  logic [REG_BIT-1:0] is_rs2_i,
  input  logic [REG_BIT-1:0] is_rd_i,
  input  logic [OP_W-1:0]    is_op_i,
  input  logic [DAT_W-1:0]   is_imm_i,
  input  logic [ADR_W-1:0]   is_pc_i,
  input  logic [ROB_BIT-1:0] rob_qd_i,
  input  logic               rob_full_i,
  input  logic               cmt_en_i,
  input  logic [REG_BIT-1:0] cmt_rd_i,
  input  logic [ROB_BIT-1:0] cmt_q_i,
  input  logic [DAT_W-1:0]   cmt_v_i,
  input  logic               br_flag_i,
  output logic               rf_en_o,
  output logic               rf_ls_o,
  output logic [ROB_BIT-1:0] rf_qj_o,
  output logic [ROB_BIT-1:0] rf_qk_o,
  output logic [DAT_W-1:0]   rf_vj_o,
  output logic [DAT_W-1:0]   rf_vk_o,
  output logic [ROB_BIT-1:0] rf_qd_o,
  output logic [OP_W-1:0]    rf_op_o,
  output logic [DAT_W-1:0]   rf_imm_o,
  output logic [ADR_W-1:0]   rf_pc_o
);

  localparam int NREG = 1 << REG_BIT;

  typedef struct packed {
    logic               ls;
    logic [ROB_BIT-1:0] qj;
    logic [ROB_BIT-1:0] qk;
    logic [DAT_W-1:0]   vj;
    logic [DAT_W-1:0]   vk;
    logic [ROB_BIT-1:0] qd;
    logic [OP_W-1:0]    op;
    logic [DAT_W-1:0]   imm;
    logic [ADR_W-1:0]   pc;
  } bundle_t;

  logic [DAT_W-1:0]   val_q [NREG];
  logic [DAT_W-1:0]   val_d [NREG];
  logic [ROB_BIT-1:0] tag_q [NREG];
  logic [ROB_BIT-1:0] tag_d [NREG];
  bundle_t            bundle_q, bundle_d;
  logic               rf_en_q, rf_en_d;

  logic               accept;
  logic               cmt_we;
  logic [REG_BIT-1:0] src [2];
  logic [ROB_BIT-1:0] q_look [2];
  logic [DAT_W-1:0]   v_look [2];

  assign accept = en && is_en_i && !rob_full_i && !br_flag_i;
  assign cmt_we = en && cmt_en_i && (cmt_rd_i != '0);
  assign src[0] = is_rs1_i;
  assign src[1] = is_rs2_i;

  // Lookup reads pre-rename state, so a source equal to rd sees the older producer.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      q_look[s] = '0;
      v_look[s] = '0;
      if (src[s] != '0) begin
        q_look[s] = tag_q[src[s]];
        v_look[s] = val_q[src[s]];
`ifdef RF_CMT_BYPASS_EN
        if (cmt_we && (cmt_rd_i == src[s]) && (tag_q[src[s]] == cmt_q_i)) begin
          q_look[s] = '0;
          v_look[s] = cmt_v_i;
        end
`endif
      end
    end
  end

  // Update order matters: commit clears, flush clears all, rename overrides both.
  always_comb begin
    val_d = val_q;
    tag_d = tag_q;
    if (cmt_we) begin
      val_d[cmt_rd_i] = cmt_v_i;
      if (tag_q[cmt_rd_i] == cmt_q_i) tag_d[cmt_rd_i] = '0;
    end
    if (en && br_flag_i) begin
      for (int i = 0; i < NREG; i++) tag_d[i] = '0;
    end
    if (accept && (is_rd_i != '0)) tag_d[is_rd_i] = rob_qd_i;
  end

  always_comb begin
    rf_en_d  = accept;
    bundle_d = bundle_q;
    if (accept) begin
      bundle_d.ls  = is_ls_i;
      bundle_d.qj  = q_look[0];
      bundle_d.qk  = q_look[1];
      bundle_d.vj  = v_look[0];
      bundle_d.vk  = v_look[1];
      bundle_d.qd  = rob_qd_i;
      bundle_d.op  = is_op_i;
      bundle_d.imm = is_imm_i;
      bundle_d.pc  = is_pc_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the register array is architecturally visible, so it is cleared on reset like any flop.
      for (int i = 0; i < NREG; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
      rf_en_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      val_q    <= val_d;
      tag_q    <= tag_d;
      rf_en_q  <= rf_en_d;
      bundle_q <= bundle_d;
    end
  end

  assign rf_en_o  = rf_en_q;
  assign rf_ls_o  = bundle_q.ls;
  assign rf_qj_o  = bundle_q.qj;
  assign rf_qk_o  = bundle_q.qk;
  assign rf_vj_o  = bundle_q.vj;
  assign rf_vk_o  = bundle_q.vk;
  assign rf_qd_o  = bundle_q.qd;
  assign rf_op_o  = bundle_q.op;
  assign rf_imm_o = bundle_q.imm;
  assign rf_pc_o  = bundle_q.pc;

endmodule

// File: tb/tb_register_file.sv
// Directed scoreboard bench for register_file: expected bundles are queued at issue
// and compared when rf_en_o pulses; idle cycles check that the bundle holds.
module tb_register_file;

  localparam int DAT_W = 32, REG_BIT = 5, ROB_BIT = 5, OP_W = 6, ADR_W = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               en = 1'b1;
  logic               is_en_i = 1'b0, is_ls_i = 1'b0;
  logic [REG_BIT-1:0] is_rs1_i = '0, is_rs2_i = '0, is_rd_i = '0;
  logic [OP_W-1:0]    is_op_i = '0;
  logic [DAT_W-1:0]   is_imm_i = '0;
  logic [ADR_W-1:0]   is_pc_i = '0;
  logic [ROB_BIT-1:0] rob_qd_i = '0;
  logic               rob_full_i = 1'b0;
  logic               cmt_en_i = 1'b0;
  logic [REG_BIT-1:0] cmt_rd_i = '0;
  logic [ROB_BIT-1:0] cmt_q_i = '0;
  logic [DAT_W-1:0]   cmt_v_i = '0;
  logic               br_flag_i = 1'b0;
  logic               rf_en_o, rf_ls_o;
  logic [ROB_BIT-1:0] rf_qj_o, rf_qk_o, rf_qd_o;
  logic [DAT_W-1:0]   rf_vj_o, rf_vk_o, rf_imm_o;
  logic [OP_W-1:0]    rf_op_o;
  logic [ADR_W-1:0]   rf_pc_o;

  register_file #(
    .DAT_W(DAT_W), .REG_BIT(REG_BIT), .ROB_BIT(ROB_BIT), .OP_W(OP_W), .ADR_W(ADR_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .is_en_i(is_en_i), .is_ls_i(is_ls_i), .is_rs1_i(is_rs1_i), .is_rs2_i(is_rs2_i),
    .is_rd_i(is_rd_i), .is_op_i(is_op_i), .is_imm_i(is_imm_i), .is_pc_i(is_pc_i),
    .rob_qd_i(rob_qd_i), .rob_full_i(rob_full_i),
    .cmt_en_i(cmt_en_i), .cmt_rd_i(cmt_rd_i), .cmt_q_i(cmt_q_i), .cmt_v_i(cmt_v_i),
    .br_flag_i(br_flag_i),
    .rf_en_o(rf_en_o), .rf_ls_o(rf_ls_o), .rf_qj_o(rf_qj_o), .rf_qk_o(rf_qk_o),
    .rf_vj_o(rf_vj_o), .rf_vk_o(rf_vk_o), .rf_qd_o(rf_qd_o), .rf_op_o(rf_op_o),
    .rf_imm_o(rf_imm_o), .rf_pc_o(rf_pc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic               ls;
    logic [ROB_BIT-1:0] qj, qk, qd;
    logic [DAT_W-1:0]   vj, vk, imm;
    logic [OP_W-1:0]    op;
    logic [ADR_W-1:0]   pc;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_e;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    chk("rf_en", {63'd0, rf_en_o}, {63'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      last_e = e;
    end else begin
      e = last_e;
    end
    chk("rf_ls",  {63'd0, rf_ls_o}, {63'd0, e.ls});
    chk("rf_qj",  64'(rf_qj_o),  64'(e.qj));
    chk("rf_qk",  64'(rf_qk_o),  64'(e.qk));
    chk("rf_vj",  64'(rf_vj_o),  64'(e.vj));
    chk("rf_vk",  64'(rf_vk_o),  64'(e.vk));
    chk("rf_qd",  64'(rf_qd_o),  64'(e.qd));
    chk("rf_op",  64'(rf_op_o),  64'(e.op));
    chk("rf_imm", 64'(rf_imm_o), 64'(e.imm));
    chk("rf_pc",  64'(rf_pc_o),  64'(e.pc));
  endtask

  // Drives one issue; the expected bundle is queued only when the issue should be accepted.
  task automatic issue(input logic [REG_BIT-1:0] rs1, input logic [REG_BIT-1:0] rs2,
                       input logic [REG_BIT-1:0] rd, input logic [ROB_BIT-1:0] qd,
                       input logic [ROB_BIT-1:0] eqj, input logic [DAT_W-1:0] evj,
                       input logic [ROB_BIT-1:0] eqk, input logic [DAT_W-1:0] evk,
                       input bit acc);
    exp_t e;
    is_en_i  = 1'b1;
    is_rs1_i = rs1;
    is_rs2_i = rs2;
    is_rd_i  = rd;
    rob_qd_i = qd;
    is_ls_i  = qd[0];
    is_op_i  = {1'b0, rd};
    is_imm_i = 32'h1000 + 32'(qd);
    is_pc_i  = 32'h400 + 32'(qd) * 4;
    if (acc) begin
      e.ls = qd[0]; e.qj = eqj; e.qk = eqk; e.qd = qd;
      e.vj = evj;   e.vk = evk; e.imm = 32'h1000 + 32'(qd);
      e.op = {1'b0, rd};        e.pc = 32'h400 + 32'(qd) * 4;
      exp_q.push_back(e);
    end
  endtask

  task automatic commit(input logic [REG_BIT-1:0] rd, input logic [ROB_BIT-1:0] q,
                        input logic [DAT_W-1:0] v);
    cmt_en_i = 1'b1;
    cmt_rd_i = rd;
    cmt_q_i  = q;
    cmt_v_i  = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_outputs();
    is_en_i    = 1'b0;
    cmt_en_i   = 1'b0;
    br_flag_i  = 1'b0;
    rob_full_i = 1'b0;
    en         = 1'b1;
  endtask

  initial begin
    last_e = '{default: '0};
    #1;
    check_outputs();
    #2 rst = 1'b1;

    // Basic issue from reset, then rename chains on x5.
    issue(3, 4, 5, 1, 0, 0, 0, 0, 1);                tick();
    issue(5, 0, 5, 2, 1, 0, 0, 0, 1);                tick();
    issue(5, 5, 0, 9, 2, 0, 2, 0, 1);                tick();
    commit(5, 1, 32'h55);                            tick();
    issue(5, 0, 0, 10, 2, 32'h55, 0, 0, 1);          tick();

    // Matching commit clears the tag of x7.
    issue(0, 0, 7, 3, 0, 0, 0, 0, 1);                tick();
    commit(7, 3, 32'hABCD);                          tick();
    issue(7, 7, 0, 11, 0, 32'hABCD, 0, 32'hABCD, 1); tick();

    // Same-cycle commit and read of x7.
    issue(0, 0, 7, 3, 0, 0, 0, 0, 1);                tick();
    commit(7, 3, 32'h10);
`ifdef RF_CMT_BYPASS_EN
    issue(7, 0, 0, 12, 0, 32'h10, 0, 0, 1);
`else
    issue(7, 0, 0, 12, 3, 32'hABCD, 0, 0, 1);
`endif
    tick();
    issue(7, 7, 0, 13, 0, 32'h10, 0, 32'h10, 1);     tick();

    // add x8,x8,x8 reads pre-rename tags; rename beats a same-cycle commit.
    issue(8, 8, 8, 4, 0, 0, 0, 0, 1);                tick();
    issue(8, 0, 0, 14, 4, 0, 0, 0, 1);               tick();
    commit(8, 4, 32'h88);
`ifdef RF_CMT_BYPASS_EN
    issue(8, 8, 8, 6, 0, 32'h88, 0, 32'h88, 1);
`else
    issue(8, 8, 8, 6, 4, 0, 4, 0, 1);
`endif
    tick();
    issue(8, 0, 0, 15, 6, 32'h88, 0, 0, 1);          tick();

    // ROB full blocks issue; outputs hold.
    rob_full_i = 1'b1;
    issue(1, 2, 1, 16, 0, 0, 0, 0, 0);               tick();

    // en low freezes everything, including commits.
    en = 1'b0;
    issue(9, 0, 9, 17, 0, 0, 0, 0, 0);
    commit(9, 0, 32'h99);                            tick();
    issue(9, 0, 0, 18, 0, 0, 0, 0, 1);               tick();

    // x0 is never written.
    commit(0, 0, 32'hDEAD);                          tick();
    issue(0, 0, 0, 19, 0, 0, 0, 0, 1);               tick();

    // Rename x1..x3, then flush with an issue and a commit in the same cycle.
    issue(0, 0, 1, 1, 0, 0, 0, 0, 1);                tick();
    issue(0, 0, 2, 2, 0, 0, 0, 0, 1);                tick();
    issue(1, 2, 3, 3, 1, 0, 2, 0, 1);                tick();
    br_flag_i = 1'b1;
    issue(1, 2, 9, 20, 0, 0, 0, 0, 0);
    commit(3, 7, 32'h33);                            tick();
    issue(1, 2, 0, 21, 0, 0, 0, 0, 1);               tick();
    issue(3, 8, 0, 22, 0, 32'h33, 0, 32'h88, 1);     tick();
    issue(9, 9, 0, 23, 0, 0, 0, 0, 1);               tick();

    // Asynchronous reset mid-stream clears outputs without a clock edge.
    issue(0, 0, 4, 5, 0, 0, 0, 0, 1);                tick();
    issue(0, 0, 5, 24, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    exp_q.delete();
    last_e = '{default: '0};
    check_outputs();
    is_en_i = 1'b0;
    rst = 1'b1;
    issue(5, 4, 0, 25, 0, 0, 0, 0, 1);               tick();
    issue(8, 7, 0, 26, 0, 0, 0, 0, 1);               tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
